game_soc_onchip_ram_burst: RTL and testbench

Parametrised successor to the SoC's single-port on-chip RAM slave. It is an Avalon-MM slave backed by an inferred RAM of 2^ADDR_W words × DATA_W bits, with byte enables. It adds burst reads and writes, a configurable registered read latency with readdatavalid, waitrequest flow control and an optional post-reset clear engine. It sits on the NIOS data master / mm_interconnect as a scratch and sprite-table store.

---
 rtl/game_soc_onchip_ram_burst_if.sv | 32 +++
 rtl/game_soc_onchip_ram_burst.sv | 168 ++++++++++++++++
 tb/tb_game_soc_onchip_ram_burst.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_soc_onchip_ram_burst_if.sv
// Avalon-MM slave bundle for the on-chip burst RAM.
// Master drives commands; slave returns data and flow control.
interface game_soc_onchip_ram_burst_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 4
) ();
  localparam int BE_W = DATA_W / 8;

  logic              chipselect;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [BURST_W-1:0] burstcount;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output chipselect, read, write, address,
    output burstcount, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address,
    input  burstcount, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/game_soc_onchip_ram_burst.sv
// Burst-capable on-chip RAM slave with registered read latency.
// Optional post-reset clear engine: GAME_SOC_RAM_CLEAR_EN.
module game_soc_onchip_ram_burst #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int BURST_W      = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  game_soc_onchip_ram_burst_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

`ifdef GAME_SOC_RAM_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE, WBURST, RBURST, CLEAR
  } state_t;
  localparam state_t RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {
    IDLE, WBURST, RBURST
  } state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [BURST_W-1:0] cnt_q, cnt_n, bc_m1;
  logic [BE_W-1:0]    wr_be;
  logic [DATA_W-1:0]  wr_data;
  logic               we, issue, accept, wait_r;
  logic               rdv_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign bc_m1 = (bus.burstcount == '0) ? '0
               : bus.burstcount - 1'b1;

  always_comb begin
    wait_r = 1'b1;
    if (clken) begin
      unique case (state)
        IDLE:    wait_r = 1'b0;
        WBURST:  wait_r = bus.read & ~bus.write;
        default: wait_r = 1'b1;
      endcase
    end
  end

  assign bus.waitrequest = wait_r;
  assign accept = bus.chipselect & (bus.read | bus.write)
                & clken & ~wait_r;

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    cnt_n   = cnt_q;
    we      = 1'b0;
    issue   = 1'b0;
    wr_addr = addr_q;
    rd_addr = addr_q;
    wr_be   = bus.byteenable;
    wr_data = bus.writedata;
    unique case (state)
      IDLE: begin
        if (accept) begin
          addr_n = bus.address + 1'b1;
          cnt_n  = bc_m1;
          // write wins when both strobes are raised
          if (bus.write) begin
            we      = 1'b1;
            wr_addr = bus.address;
            if (bc_m1 != '0) state_n = WBURST;
          end else begin
            issue   = 1'b1;
            rd_addr = bus.address;
            if (bc_m1 != '0) state_n = RBURST;
          end
        end
      end
      WBURST: begin
        if (bus.chipselect & bus.write & clken) begin
          we     = 1'b1;
          addr_n = addr_q + 1'b1;
          cnt_n  = cnt_q - 1'b1;
          if (cnt_q == BURST_W'(1)) state_n = IDLE;
        end
      end
      RBURST: begin
        if (clken) begin
          issue  = 1'b1;
          addr_n = addr_q + 1'b1;
          cnt_n  = cnt_q - 1'b1;
          if (cnt_q == BURST_W'(1)) state_n = IDLE;
        end
      end
`ifdef GAME_SOC_RAM_CLEAR_EN
      CLEAR: begin
        if (clken) begin
          we      = 1'b1;
          wr_be   = '1;
          wr_data = '0;
          addr_n  = addr_q + 1'b1;
          if (&addr_q) state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RST_STATE;
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (clken) begin
      state  <= state_n;
      addr_q <= addr_n;
      cnt_q  <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i])
          mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          bus.readdata <= '0;
          rdv_q        <= 1'b0;
        end else if (clken) begin
          rdv_q <= issue;
          if (issue) bus.readdata <= mem[rd_addr];
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] ram_q;
      logic              v1_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ram_q        <= '0;
          v1_q         <= 1'b0;
          bus.readdata <= '0;
          rdv_q        <= 1'b0;
        end else if (clken) begin
          v1_q  <= issue;
          rdv_q <= v1_q;
          if (issue) ram_q <= mem[rd_addr];
          if (v1_q)  bus.readdata <= ram_q;
        end
      end
    end
  endgenerate

  // a frozen beat must not be seen twice while clken is low
  assign bus.readdatavalid = rdv_q & clken;
endmodule

// File: tb/tb_game_soc_onchip_ram_burst.sv
// Random and directed bench for the burst RAM slave.
// Reference: word array plus a queue of expected read beats.
module tb_game_soc_onchip_ram_burst;
  localparam int L = 2;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic clken;
  int   cyc = 0;
  int   n_chk;
  int   n_err;
  int   st;

  logic [31:0] m [256];
  exp_t        eq[$];
  int          vcyc[$];
  logic [31:0] dq[$];
  logic [3:0]  bq[$];

  game_soc_onchip_ram_burst_if #(
    .DATA_W(32), .ADDR_W(8), .BURST_W(4)
  ) bus ();

  game_soc_onchip_ram_burst #(
    .DATA_W(32), .ADDR_W(8),
    .BURST_W(4), .READ_LATENCY(L)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clken(clken),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && bus.readdatavalid) begin
      vcyc.push_back(cyc);
      if (eq.size() == 0) begin
        chk("rdv_extra", 64'(bus.readdatavalid), 64'(0));
      end else begin
        e = eq.pop_front();
        chk("rdata", 64'(bus.readdata), 64'(e.d));
        if (e.c >= 0) chk("rlat", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic wait_acc();
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!bus.waitrequest && clken) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 64'(ok), 64'(1));
  endtask

  task automatic wr_burst(input logic [7:0] a, input bit gaps);
    int n = dq.size();
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.read       = 1'b0;
    bus.address    = a;
    bus.burstcount = 4'(n);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(3) == 0) begin
        bus.write = 1'b0;
        @(posedge clk); #1;
      end
      bus.write      = 1'b1;
      bus.byteenable = bq[i];
      bus.writedata  = dq[i];
      wait_acc();
      for (int b = 0; b < 4; b++)
        if (bq[i][b]) m[8'(a + i)][8*b +: 8] = dq[i][8*b +: 8];
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic rd_cmd(input logic [7:0] a, input logic [3:0] bc,
                        input bit timed, output int stall);
    int   n;
    int   c0;
    exp_t e;
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = a;
    bus.burstcount = bc;
    wait_acc();
    c0 = cyc;
    n  = (bc == 0) ? 1 : int'(bc);
    for (int i = 0; i < n; i++) begin
      e.d = m[8'(a + i)];
      e.c = timed ? c0 + L + i : -1;
      eq.push_back(e);
    end
    @(posedge clk); #1;
    idle();
    stall = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.waitrequest) break;
      stall++;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && eq.size() != 0; k++)
      @(negedge clk);
    #2;
    chk("drain", 64'(eq.size()), 64'(0));
  endtask

  initial begin
    int g;
    n_chk = 0;
    n_err = 0;
    clken = 1'b1;
    reset_n = 1'b1;
    idle();
    bus.address    = '0;
    bus.burstcount = '0;
    bus.byteenable = '0;
    bus.writedata  = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdv", 64'(bus.readdatavalid), 64'(0));
    chk("rst_rdata", 64'(bus.readdata), 64'(0));
    chk("rst_wait", 64'(bus.waitrequest), 64'(0));
    @(posedge clk); #1 reset_n = 1'b1;

    for (int blk = 0; blk < 32; blk++) begin
      dq.delete(); bq.delete();
      for (int i = 0; i < 8; i++) begin
        dq.push_back($urandom);
        bq.push_back(4'hF);
      end
      wr_burst(8'(blk * 8), 1'b0);
    end

    // single writes with lane merge, then timed read
    dq.delete(); bq.delete();
    dq.push_back(32'hDEADBEEF); bq.push_back(4'hF);
    wr_burst(8'd5, 1'b0);
    dq.delete(); bq.delete();
    dq.push_back(32'h00007700); bq.push_back(4'b0010);
    wr_burst(8'd5, 1'b0);
    rd_cmd(8'd5, 4'd1, 1'b1, st);
    chk("t1_stall", 64'(st), 64'(0));
    drain();
    chk("t1_data", 64'(bus.readdata), 64'(32'hDEAD77EF));

    // wrap-around bursts
    dq.delete(); bq.delete();
    for (int i = 1; i <= 4; i++) begin
      dq.push_back(32'(i));
      bq.push_back(4'hF);
    end
    wr_burst(8'hFE, 1'b1);
    rd_cmd(8'hFE, 4'd4, 1'b1, st);
    chk("t2_stall", 64'(st), 64'(3));
    drain();
    chk("t2_last", 64'(bus.readdata), 64'(4));

    // burstcount 0, then read+write together
    rd_cmd(8'd3, 4'd0, 1'b1, st);
    chk("t3_stall", 64'(st), 64'(0));
    drain();
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 8'd3;
    bus.burstcount = 4'd1;
    bus.byteenable = 4'hF;
    bus.writedata  = 32'h12345678;
    wait_acc();
    m[3] = 32'h12345678;
    @(posedge clk); #1;
    idle();
    repeat (5) @(negedge clk);
    rd_cmd(8'd3, 4'd1, 1'b1, st);
    drain();
    chk("t3_rw", 64'(bus.readdata), 64'(32'h12345678));

    // clock-enable gap inside a read burst
    vcyc.delete();
    fork
      rd_cmd(8'h40, 4'd8, 1'b0, st);
      begin
        repeat (5) @(posedge clk);
        #1 clken = 1'b0;
        repeat (2) @(posedge clk);
        #1 clken = 1'b1;
      end
    join
    chk("ck_stall", 64'(st), 64'(9));
    drain();
    chk("ck_beats", 64'(vcyc.size()), 64'(8));
    g = 0;
    for (int i = 1; i < vcyc.size(); i++)
      g += vcyc[i] - vcyc[i-1] - 1;
    chk("ck_gap", 64'(g), 64'(2));

    // reset on the third beat of a burst
    vcyc.delete();
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 8'h80;
    bus.burstcount = 4'd8;
    wait_acc();
    begin
      exp_t e;
      for (int i = 0; i < 8; i++) begin
        e.d = m[8'(8'h80 + i)];
        e.c = cyc + L + i;
        eq.push_back(e);
      end
    end
    @(posedge clk); #1;
    idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #2;
      if (vcyc.size() >= 3) break;
    end
    chk("rs_beats", 64'(vcyc.size()), 64'(3));
    reset_n = 1'b0;
    #1;
    chk("rs_rdv", 64'(bus.readdatavalid), 64'(0));
    eq.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rs_wait", 64'(bus.waitrequest), 64'(0));
    chk("rs_rdata", 64'(bus.readdata), 64'(0));
    repeat (5) @(negedge clk);
    rd_cmd(8'h80, 4'd8, 1'b1, st);
    chk("rs_stall", 64'(st), 64'(7));
    drain();

    // random traffic
    for (int t = 0; t < 40; t++) begin
      logic [7:0] a;
      logic [3:0] bc;
      int         n;
      a = 8'($urandom);
      n = $urandom_range(1, 8);
      if ($urandom_range(1) == 1) begin
        dq.delete(); bq.delete();
        for (int i = 0; i < n; i++) begin
          dq.push_back($urandom);
          bq.push_back(4'($urandom_range(1, 15)));
        end
        wr_burst(a, 1'b1);
      end else begin
        bc = ($urandom_range(3) == 0) ? 4'd0 : 4'(n);
        rd_cmd(a, bc, 1'b1, st);
        chk("rnd_stall", 64'(st),
            64'((bc == 0) ? 0 : n - 1));
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
